// File: rtl/serial_master_port.sv
`default_nettype none
// ============================================================================
// Module      : serial_master_port
// Description : Master-side serializer/deserializer for the single-bit serial
//               system bus. Accepts one parallel read/write request from a
//               bus-master device, shifts the address (and write data) onto
//               the bus LSB-first, and for reads assembles the slave's serial
//               reply into a parallel word.
// Ports       : clk, rstn          - clock, synchronous active-low reset
//               dvalid/dwen/daddr/dwdata - device request (dvalid && dready)
//               dready/drdata/ddone/derr - device status / read data
//               mwdata/mmode/mvalid      - serial bus outputs to the slave
//               srdata/svalid            - serial read reply from the slave
// Options     : `define MASTER_PORT_TIMEOUT_EN enables an RWAIT watchdog that
//               aborts a read after TIMEOUT_CYCLES with a derr pulse. When
//               undefined, derr is tied low and no wait counter exists.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_master_port #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dvalid,
  input  logic                  dwen,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dready,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  ddone,
  output logic                  derr,
  output logic                  mwdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  srdata,
  input  logic                  svalid
);

  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] c_ADDR_END  = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] c_DATA_END  = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] c_DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_ADDR  = 3'd1;
  localparam logic [2:0] c_WDATA = 3'd2;
  localparam logic [2:0] c_RWAIT = 3'd3;
  localparam logic [2:0] c_RDATA = 3'd4;
  localparam logic [2:0] c_DONE  = 3'd5;

  logic [2:0]            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  // Address / write-data latches are shifted right as bits go out, so the
  // next bit to drive is always at index 1 (index 0 is already on the bus).
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  // Read data shifts in from the MSB end; after DATA_WIDTH captures the first
  // received bit sits at bit 0.
  logic [DATA_WIDTH-1:0] r_rbuf, w_rbuf_nxt;
  logic                  r_dready, w_dready_nxt;
  logic [DATA_WIDTH-1:0] r_drdata, w_drdata_nxt;
  logic                  r_ddone, w_ddone_nxt;
  logic                  r_mwdata, w_mwdata_nxt;
  logic                  r_mmode, w_mmode_nxt;
  logic                  r_mvalid, w_mvalid_nxt;

`ifdef MASTER_PORT_TIMEOUT_EN
  localparam int                WAIT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] r_wait, w_wait_nxt;
  logic              r_derr, w_derr_nxt;
  logic              w_timeout;

  // Fires on the TIMEOUT_CYCLES-th consecutive RWAIT cycle without svalid.
  assign w_timeout = (r_state == c_RWAIT) && !svalid && (r_wait == c_WAIT_LAST);
`endif

  // State register and registered outputs/datapath
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= c_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rbuf   <= '0;
      r_dready <= 1'b1;
      r_drdata <= '0;
      r_ddone  <= 1'b0;
      r_mwdata <= 1'b0;
      r_mmode  <= 1'b0;
      r_mvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_rbuf   <= w_rbuf_nxt;
      r_dready <= w_dready_nxt;
      r_drdata <= w_drdata_nxt;
      r_ddone  <= w_ddone_nxt;
      r_mwdata <= w_mwdata_nxt;
      r_mmode  <= w_mmode_nxt;
      r_mvalid <= w_mvalid_nxt;
    end
  end

`ifdef MASTER_PORT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wait <= '0;
      r_derr <= 1'b0;
    end else begin
      r_wait <= w_wait_nxt;
      r_derr <= w_derr_nxt;
    end
  end
`endif

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (dvalid) w_state_nxt = c_ADDR;
      c_ADDR:  if (r_cnt == c_ADDR_END) w_state_nxt = r_mmode ? c_WDATA : c_RWAIT;
      c_WDATA: if (r_cnt == c_DATA_END) w_state_nxt = c_DONE;
      c_RWAIT: begin
        if (svalid) w_state_nxt = c_RDATA;
`ifdef MASTER_PORT_TIMEOUT_EN
        else if (w_timeout) w_state_nxt = c_IDLE;
`endif
      end
      c_RDATA: if (svalid && (r_cnt == c_DATA_LAST)) w_state_nxt = c_DONE;
      c_DONE:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_rbuf_nxt   = r_rbuf;
    w_dready_nxt = r_dready;
    w_drdata_nxt = r_drdata;
    w_ddone_nxt  = 1'b0;
    w_mwdata_nxt = r_mwdata;
    w_mmode_nxt  = r_mmode;
    w_mvalid_nxt = r_mvalid;
`ifdef MASTER_PORT_TIMEOUT_EN
    w_wait_nxt   = r_wait;
    w_derr_nxt   = 1'b0;
`endif
    case (r_state)
      c_IDLE: begin
        w_dready_nxt = 1'b1;
        if (dvalid) begin
          w_addr_nxt   = daddr;
          w_wdata_nxt  = dwdata;
          w_dready_nxt = 1'b0;
          w_mmode_nxt  = dwen;
          w_mvalid_nxt = 1'b1;
          w_mwdata_nxt = daddr[0];
          w_cnt_nxt    = CNT_W'(1);
        end
      end
      c_ADDR: begin
        if (r_cnt == c_ADDR_END) begin
          if (r_mmode) begin
            w_mwdata_nxt = r_wdata[0];
            w_cnt_nxt    = CNT_W'(1);
          end else begin
            w_mvalid_nxt = 1'b0;
            w_mwdata_nxt = 1'b0;
            w_cnt_nxt    = '0;
`ifdef MASTER_PORT_TIMEOUT_EN
            w_wait_nxt   = '0;
`endif
          end
        end else begin
          w_mwdata_nxt = r_addr[1];
          w_addr_nxt   = r_addr >> 1;
          w_cnt_nxt    = r_cnt + 1'b1;
        end
      end
      c_WDATA: begin
        if (r_cnt == c_DATA_END) begin
          w_mvalid_nxt = 1'b0;
          w_mwdata_nxt = 1'b0;
          w_ddone_nxt  = 1'b1;
          w_cnt_nxt    = '0;
        end else begin
          w_mwdata_nxt = r_wdata[1];
          w_wdata_nxt  = r_wdata >> 1;
          w_cnt_nxt    = r_cnt + 1'b1;
        end
      end
      c_RWAIT: begin
        if (svalid) begin
          w_rbuf_nxt = {srdata, r_rbuf[DATA_WIDTH-1:1]};
          w_cnt_nxt  = CNT_W'(1);
        end
`ifdef MASTER_PORT_TIMEOUT_EN
        else if (w_timeout) begin
          w_derr_nxt   = 1'b1;
          w_dready_nxt = 1'b1;
          w_mmode_nxt  = 1'b0;
          w_cnt_nxt    = '0;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
`endif
      end
      c_RDATA: begin
        if (svalid) begin
          w_rbuf_nxt = {srdata, r_rbuf[DATA_WIDTH-1:1]};
          if (r_cnt == c_DATA_LAST) begin
            w_drdata_nxt = {srdata, r_rbuf[DATA_WIDTH-1:1]};
            w_ddone_nxt  = 1'b1;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      c_DONE: begin
        // Leaving DONE gives the bus a second mvalid-low cycle before the
        // next request can be accepted in IDLE.
        w_dready_nxt = 1'b1;
        w_mmode_nxt  = 1'b0;
        w_cnt_nxt    = '0;
      end
      default: begin
        w_dready_nxt = 1'b1;
        w_mvalid_nxt = 1'b0;
        w_mmode_nxt  = 1'b0;
        w_cnt_nxt    = '0;
      end
    endcase
  end

  assign dready = r_dready;
  assign drdata = r_drdata;
  assign ddone  = r_ddone;
  assign mwdata = r_mwdata;
  assign mmode  = r_mmode;
  assign mvalid = r_mvalid;
`ifdef MASTER_PORT_TIMEOUT_EN
  assign derr   = r_derr;
`else
  assign derr   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_master_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_master_port
// Description : Directed self-checking bench for serial_master_port: reset,
//               write shifting, reads against a simple slave model, gapped
//               svalid, busy/back-to-back requests, reset mid-write, and the
//               RWAIT timeout when MASTER_PORT_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_master_port;

  logic        clk;
  logic        rstn;
  logic        dvalid;
  logic        dwen;
  logic [11:0] daddr;
  logic [7:0]  dwdata;
  logic        dready;
  logic [7:0]  drdata;
  logic        ddone;
  logic        derr;
  logic        mwdata;
  logic        mmode;
  logic        mvalid;
  logic        srdata;
  logic        svalid;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_rd;

  serial_master_port #(
    .ADDR_WIDTH    (12),
    .DATA_WIDTH    (8),
    .TIMEOUT_CYCLES(16)
  ) u_dut (
    .clk   (clk),
    .rstn  (rstn),
    .dvalid(dvalid),
    .dwen  (dwen),
    .daddr (daddr),
    .dwdata(dwdata),
    .dready(dready),
    .drdata(drdata),
    .ddone (ddone),
    .derr  (derr),
    .mwdata(mwdata),
    .mmode (mmode),
    .mvalid(mvalid),
    .srdata(srdata),
    .svalid(svalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the acceptance edge of a write. Checks the 20-bit bus
  // stream, DONE and the following idle cycle. When busy is set, dvalid is
  // toggled with a junk request mid-transfer and then held with (a2,d2).
  task automatic write_body(input string tag, input logic [11:0] a, input logic [7:0] d,
                            input logic busy, input logic [11:0] a2, input logic [7:0] d2);
    logic [19:0] cap;
    logic        allv, allm, early;
    allv = 1'b1; allm = 1'b1; early = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cap[i] = mwdata;
      allv &= mvalid;
      allm &= mmode;
      early |= ddone | derr | dready;
      if (busy) begin
        if (i >= 3 && i <= 7) begin
          dvalid = i[0];
          dwen   = 1'b0;
          daddr  = 12'hFFF;
          dwdata = 8'hFF;
        end
        if (i == 10) begin
          dvalid = 1'b1;
          dwen   = 1'b1;
          daddr  = a2;
          dwdata = d2;
        end
      end
      tick();
    end
    chk({tag, "_stream"}, 32'(cap), 32'({d, a}));
    chk({tag, "_mvalid_cont"}, 32'(allv), 32'd1);
    chk({tag, "_mmode_hi"}, 32'(allm), 32'd1);
    chk({tag, "_no_early_done"}, 32'(early), 32'd0);
    chk({tag, "_ddone"}, 32'(ddone), 32'd1);
    chk({tag, "_mvalid_off"}, 32'(mvalid), 32'd0);
    chk({tag, "_drdata_kept"}, 32'(drdata), 32'(exp_rd));
    tick();
    chk({tag, "_ddone_pulse"}, 32'(ddone), 32'd0);
    chk({tag, "_idle"}, 32'({dready, mvalid, mmode}), 32'b100);
  endtask

  task automatic do_write(input string tag, input logic [11:0] a, input logic [7:0] d);
    dvalid = 1'b1; dwen = 1'b1; daddr = a; dwdata = d;
    tick();
    dvalid = 1'b0;
    write_body(tag, a, d, 1'b0, 12'h000, 8'h00);
  endtask

  // Read against a slave model: ta idle cycles after the address phase,
  // then 8 bits LSB-first, with svalid dropped for gap cycles after bit 4.
  task automatic do_read(input string tag, input logic [11:0] a, input logic [7:0] d,
                         input int ta, input int gap);
    logic [11:0] cap;
    logic        allv, anym, early;
    allv = 1'b1; anym = 1'b0; early = 1'b0;
    dvalid = 1'b1; dwen = 1'b0; daddr = a; dwdata = 8'hEE;
    tick();
    dvalid = 1'b0;
    // junk on the reply lines during the address phase must be ignored
    svalid = 1'b1; srdata = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cap[i] = mwdata;
      allv &= mvalid;
      anym |= mmode;
      early |= ddone | derr;
      tick();
    end
    svalid = 1'b0; srdata = 1'b0;
    chk({tag, "_addr"}, 32'(cap), 32'(a));
    chk({tag, "_mvalid_addr"}, 32'(allv), 32'd1);
    chk({tag, "_mmode_lo"}, 32'(anym), 32'd0);
    chk({tag, "_mvalid_off"}, 32'(mvalid), 32'd0);
    for (int i = 0; i < ta; i++) begin
      early |= ddone | derr | mvalid;
      tick();
    end
    for (int j = 0; j < 8; j++) begin
      svalid = 1'b1; srdata = d[j];
      early |= ddone | derr | mvalid;
      tick();
      if (j == 4) begin
        for (int k = 0; k < gap; k++) begin
          svalid = 1'b0; srdata = ~d[5];
          early |= ddone | derr;
          tick();
        end
      end
    end
    svalid = 1'b0; srdata = 1'b0;
    chk({tag, "_no_early_done"}, 32'(early), 32'd0);
    chk({tag, "_ddone"}, 32'(ddone), 32'd1);
    chk({tag, "_drdata"}, 32'(drdata), 32'(d));
    exp_rd = d;
    tick();
    chk({tag, "_ddone_pulse"}, 32'(ddone), 32'd0);
    chk({tag, "_idle"}, 32'({dready, mvalid, mmode}), 32'b100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef MASTER_PORT_TIMEOUT_EN
    int   n;
    logic seen;
`endif
    rstn = 1'b0; dvalid = 1'b1; dwen = 1'b1; daddr = 12'h123; dwdata = 8'h45;
    srdata = 1'b0; svalid = 1'b0; exp_rd = 8'h00;
    repeat (3) tick();
    chk("rst_dready", 32'(dready), 32'd1);
    chk("rst_outs", 32'({drdata, ddone, derr, mwdata, mmode, mvalid}), 32'd0);
    dvalid = 1'b0; rstn = 1'b1;
    tick();
    chk("rst_release", 32'({dready, mvalid, ddone}), 32'b100);

    do_write("wr1", 12'hA5C, 8'h3B);
    do_read("rd1", 12'h00F, 8'hC6, 2, 0);
    do_read("rd_gap", 12'h5A3, 8'h96, 2, 3);
    do_write("wr_keep", 12'h001, 8'h80);

    // busy / back-to-back: dvalid held, second request accepted after DONE
    dvalid = 1'b1; dwen = 1'b1; daddr = 12'h3C1; dwdata = 8'h7E;
    tick();
    write_body("busy1", 12'h3C1, 8'h7E, 1'b1, 12'hB42, 8'h19);
    tick();
    chk("busy2_accept", 32'({dready, mvalid, mwdata}), 32'b010);
    dvalid = 1'b0;
    write_body("busy2", 12'hB42, 8'h19, 1'b0, 12'h000, 8'h00);

    // reset while wdata bit 3 is on the bus
    dvalid = 1'b1; dwen = 1'b1; daddr = 12'hFFF; dwdata = 8'h08;
    tick();
    dvalid = 1'b0;
    repeat (15) tick();
    chk("mid_bit3", 32'({mvalid, mwdata}), 32'b11);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("mid_rst", 32'({mvalid, ddone, dready, drdata}), 32'h100);
    exp_rd = 8'h00;
    tick();
    chk("mid_no_done", 32'({ddone, mvalid}), 32'd0);
    do_read("rd_after_rst", 12'h123, 8'h5A, 1, 0);

`ifdef MASTER_PORT_TIMEOUT_EN
    dvalid = 1'b1; dwen = 1'b0; daddr = 12'h0F0;
    tick();
    dvalid = 1'b0;
    repeat (12) tick();
    chk("to_mvalid", 32'(mvalid), 32'd0);
    n = 0; seen = 1'b0;
    while (!derr && n < 100) begin
      seen |= ddone;
      tick();
      n++;
    end
    chk("to_cycles", 32'(n), 32'd16);
    chk("to_derr", 32'(derr), 32'd1);
    chk("to_no_done", 32'(seen | ddone), 32'd0);
    chk("to_drdata", 32'(drdata), 32'(exp_rd));
    chk("to_dready", 32'(dready), 32'd1);
    tick();
    chk("to_derr_pulse", 32'(derr), 32'd0);
`else
    // without the watchdog a long slave turnaround simply waits
    do_read("rd_long", 12'h7E1, 8'h81, 40, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
